// File: rtl/sr_bank_pkg.sv
// Shared definitions for the SR state-bit bank arbiter.
//   CMD_*    : command encoding of the {s, r} pair carried by each request
//   sr_to_t  : toggle enable that makes a T cell behave as an SR latch bit
package sr_bank_pkg;

    localparam logic [1:0] CMD_HOLD    = 2'b00;
    localparam logic [1:0] CMD_RESET   = 2'b01;
    localparam logic [1:0] CMD_SET     = 2'b10;
    localparam logic [1:0] CMD_ILLEGAL = 2'b11;

    // Toggle only when the requested level differs from the current one:
    // a set of a clear bit, or a reset of a set bit.
    function automatic logic sr_to_t(
        input logic s,
        input logic r,
        input logic q,
        input logic q_bar
    );
        return (s & q_bar) | (r & q);
    endfunction

endpackage

// File: rtl/sr_toggle_cell.sv
// One state bit of the bank, built as a toggle cell.
//   i_clock : rising-edge clock
//   i_rst   : synchronous active-low reset (q=0, q_bar=1)
//   i_t     : toggle enable; flips q and q_bar together when 1
//   o_q     : stored bit
//   o_q_bar : complement of the stored bit
module sr_toggle_cell (
    input  logic i_clock,
    input  logic i_rst,
    input  logic i_t,
    output logic o_q,
    output logic o_q_bar
);

    logic r_q;
    logic r_q_bar;

    // Both rails are stored and flipped together so they can never diverge.
    always_ff @(posedge i_clock) begin
        if (!i_rst) begin
            r_q     <= 1'b0;
            r_q_bar <= 1'b1;
        end else if (i_t) begin
            r_q     <= ~r_q;
            r_q_bar <= ~r_q_bar;
        end
    end

    assign o_q     = r_q;
    assign o_q_bar = r_q_bar;

endmodule

// File: rtl/sr_bank_arbiter.sv
// Round-robin arbiter in front of a bank of SR-behaving state bits.
// One command per cycle is granted, applied to the bank, and answered
// with a registered one-cycle acknowledge carrying the resulting bit value.
//   i_clock     : rising-edge clock
//   i_rst       : synchronous active-low reset
//   i_req_valid : per-requester command valid, held until acknowledged
//   i_req_s     : per-requester set bit
//   i_req_r     : per-requester reset bit
//   i_req_idx   : per-requester bit index, requester k at [k*IDXW +: IDXW]
//   o_ack       : one-hot acknowledge pulse for the serviced requester
//   o_rsp_q     : target bit value after the command (valid with o_ack)
//   o_rsp_err   : command was illegal (s=r=1) or index out of range
//   o_q         : bank state
//   o_q_bar     : complement of the bank state
module sr_bank_arbiter
    import sr_bank_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int IDXW  = 3
) (
    input  logic                 i_clock,
    input  logic                 i_rst,
    input  logic [NREQ-1:0]      i_req_valid,
    input  logic [NREQ-1:0]      i_req_s,
    input  logic [NREQ-1:0]      i_req_r,
    input  logic [NREQ*IDXW-1:0] i_req_idx,
    output logic [NREQ-1:0]      o_ack,
    output logic                 o_rsp_q,
    output logic                 o_rsp_err,
    output logic [NBITS-1:0]     o_q,
    output logic [NBITS-1:0]     o_q_bar
);

    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTRW-1:0]  r_ptr;
    logic [NREQ-1:0]  r_ack;
    logic             r_rsp_q;
    logic             r_rsp_err;

    logic [NREQ-1:0]  w_elig;
    logic             w_any;
    logic [PTRW-1:0]  w_win;
    logic [PTRW-1:0]  w_ptr_next;
    logic [NREQ-1:0]  w_ack_next;
    logic             w_s;
    logic             w_r;
    logic [IDXW-1:0]  w_idx;
    logic             w_illegal;
    logic             w_in_range;
    logic             w_cur_q;
    logic             w_cur_q_bar;
    logic             w_t_en;
    logic             w_post_q;
    logic [NBITS-1:0] w_t;
    logic [NBITS-1:0] w_q;
    logic [NBITS-1:0] w_q_bar;

    // A requester acknowledged this cycle still shows its held valid;
    // masking it keeps the same command from being served twice.
    assign w_elig = i_req_valid & ~r_ack;

    // Scan upward from the pointer, wrapping at NREQ; first eligible wins.
    always_comb begin
        int j;
        w_any = 1'b0;
        w_win = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(r_ptr) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!w_any && w_elig[j]) begin
                w_any = 1'b1;
                w_win = PTRW'(j);
            end
        end
    end

    assign w_ptr_next = (w_win == PTRW'(NREQ - 1)) ? '0 : w_win + PTRW'(1);

    // Fetch the winning requester's command.
    always_comb begin
        w_s   = 1'b0;
        w_r   = 1'b0;
        w_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_win == PTRW'(k)) begin
                w_s   = i_req_s[k];
                w_r   = i_req_r[k];
                w_idx = i_req_idx[k*IDXW +: IDXW];
            end
        end
    end

    always_comb begin
        unique case ({w_s, w_r})
            CMD_HOLD, CMD_SET, CMD_RESET: w_illegal = 1'b0;
            CMD_ILLEGAL:                  w_illegal = 1'b1;
            default:                      w_illegal = 1'b0;
        endcase
    end

    assign w_in_range = (int'(w_idx) < NBITS);

    // Current level of the target bit; reads as 0 when out of range.
    always_comb begin
        w_cur_q     = 1'b0;
        w_cur_q_bar = 1'b1;
        for (int i = 0; i < NBITS; i++) begin
            if (w_idx == IDXW'(i)) begin
                w_cur_q     = w_q[i];
                w_cur_q_bar = w_q_bar[i];
            end
        end
    end

    assign w_t_en   = w_any & ~w_illegal & w_in_range
                    & sr_to_t(w_s, w_r, w_cur_q, w_cur_q_bar);
    assign w_post_q = w_cur_q ^ w_t_en;

    generate
        for (genvar gi = 0; gi < NBITS; gi++) begin : g_bit
            assign w_t[gi] = w_t_en & (w_idx == IDXW'(gi));

            sr_toggle_cell u_cell (
                .i_clock (i_clock),
                .i_rst   (i_rst),
                .i_t     (w_t[gi]),
                .o_q     (w_q[gi]),
                .o_q_bar (w_q_bar[gi])
            );
        end

        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ack
            assign w_ack_next[gi] = w_any & (w_win == PTRW'(gi));
        end
    endgenerate

    // Response registers hold their last value across idle cycles.
    always_ff @(posedge i_clock) begin
        if (!i_rst) begin
            r_ptr     <= '0;
            r_ack     <= '0;
            r_rsp_q   <= 1'b0;
            r_rsp_err <= 1'b0;
        end else begin
            r_ack <= w_ack_next;
            if (w_any) begin
                r_ptr     <= w_ptr_next;
                r_rsp_q   <= w_post_q;
                r_rsp_err <= w_illegal | ~w_in_range;
            end
        end
    end

    assign o_ack     = r_ack;
    assign o_rsp_q   = r_rsp_q;
    assign o_rsp_err = r_rsp_err;
    assign o_q       = w_q;
    assign o_q_bar   = w_q_bar;

endmodule
